// File: rtl/node_info_engine.sv
// Per-node state block: decodes one packet per en_MNI strobe and keeps hop count, Q-value, CH role, timeslot, round state.
// Latency: commit 2 edges after the accepting edge. Packets strobed while busy are dropped silently (no queue).
module node_info_engine #(
    parameter int                  WORD_WIDTH  = 16,
    parameter int                  FRAC_BITS   = 14,
    parameter logic [WORD_WIDTH-1:0] NODE_ID     = 16'h000C,
    parameter logic [WORD_WIDTH-1:0] HOP_PENALTY = 16'h0400,
    parameter int                  TS_WIDTH    = 8,
    parameter int                  RC_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_MNI,
    input  logic [2:0]            fPktType,
    input  logic [WORD_WIDTH-1:0] energy,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic [WORD_WIDTH-1:0] hops,
    input  logic [WORD_WIDTH-1:0] timeslot,
    input  logic [WORD_WIDTH-1:0] e_threshold,
    output logic [WORD_WIDTH-1:0] myNodeID,
    output logic [WORD_WIDTH-1:0] hopsFromSink,
    output logic [WORD_WIDTH-1:0] myQValue,
    output logic                  role,
    output logic                  low_E,
    output logic                  hb_lock,
    output logic [TS_WIDTH-1:0]   myTimeslot,
    output logic                  ts_valid,
    output logic [RC_WIDTH-1:0]   round_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  pkt_dropped
);

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_CHTS = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    localparam int PW = 2 * WORD_WIDTH;

    // The fixed-point words need at least one integer bit.
    if (FRAC_BITS >= WORD_WIDTH) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than WORD_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]            type_q;
    logic [WORD_WIDTH-1:0] energy_q;
    logic [WORD_WIDTH-1:0] dest_q;
    logic [WORD_WIDTH-1:0] hops_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [WORD_WIDTH-1:0] thr_q;
    logic [WORD_WIDTH-1:0] h_q;
    logic [PW-1:0]         prod_q;

    logic                  accept;
    logic [WORD_WIDTH-1:0] h_nxt;
    logic [PW-1:0]         prod_nxt;
    logic [WORD_WIDTH-1:0] q_val;
    logic                  dest_match;

    if (TS_WIDTH < WORD_WIDTH) begin : g_ts_unused
        logic unused_ts_hi;
        assign unused_ts_hi = ^timeslot[WORD_WIDTH-1:TS_WIDTH];
    end

    assign myNodeID = NODE_ID;
    assign busy     = (state != ST_IDLE);
    assign accept   = (state == ST_IDLE) && en_MNI;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (en_MNI) state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            type_q   <= '0;
            energy_q <= '0;
            dest_q   <= '0;
            hops_q   <= '0;
            ts_q     <= '0;
            thr_q    <= '0;
        end else if (accept) begin
            type_q   <= fPktType;
            energy_q <= energy;
            dest_q   <= destinationID;
            hops_q   <= hops;
            ts_q     <= timeslot[TS_WIDTH-1:0];
            thr_q    <= e_threshold;
        end
    end

    // h is an integer hop count, so h*HOP_PENALTY already sits on energy's fixed-point scale.
    assign h_nxt    = (&hops_q) ? hops_q : hops_q + 1'b1;
    assign prod_nxt = {{WORD_WIDTH{1'b0}}, h_nxt} * {{WORD_WIDTH{1'b0}}, HOP_PENALTY};

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            h_q    <= '0;
            prod_q <= '0;
        end else if (state == ST_EXEC) begin
            h_q    <= h_nxt;
            prod_q <= prod_nxt;
        end
    end

    assign q_val      = (prod_q >= {{WORD_WIDTH{1'b0}}, energy_q}) ? '0
                                                                    : energy_q - prod_q[WORD_WIDTH-1:0];
    assign dest_match = (dest_q == NODE_ID);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            hopsFromSink <= '1;
            myQValue     <= '0;
            role         <= 1'b0;
            low_E        <= 1'b0;
            hb_lock      <= 1'b0;
            myTimeslot   <= '0;
            ts_valid     <= 1'b0;
            round_cnt    <= '0;
            done         <= 1'b0;
            pkt_dropped  <= 1'b0;
        end else begin
            done        <= 1'b0;
            pkt_dropped <= 1'b0;
            if (state == ST_COMMIT) begin
                done <= 1'b1;
                case (type_q)
                    PKT_HB: begin
                        if (hb_lock) begin
                            pkt_dropped <= 1'b1;
                        end else begin
                            hopsFromSink <= h_q;
                            myQValue     <= q_val;
                            low_E        <= (energy_q < thr_q);
                            hb_lock      <= 1'b1;
                            role         <= 1'b0;
                            ts_valid     <= 1'b0;
                            round_cnt    <= round_cnt + 1'b1;
                        end
                    end
                    PKT_CHE: begin
                        if (dest_match && hb_lock) role <= 1'b1;
                    end
                    PKT_CHTS: begin
                        if (!role && dest_match) begin
                            myTimeslot <= ts_q;
                            ts_valid   <= 1'b1;
                        end
                    end
                    PKT_DATA: hb_lock <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_node_info_engine.sv
// Directed scenarios plus randomized packet streams, each checked against a rule-level model of node state.
module tb_node_info_engine;

    localparam logic [15:0] NID = 16'h000C;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en_MNI;
    logic [2:0]  fPktType;
    logic [15:0] energy, destinationID, hops, timeslot, e_threshold;
    logic [15:0] myNodeID, hopsFromSink, myQValue;
    logic        role, low_E, hb_lock, ts_valid, busy, done, pkt_dropped;
    logic [7:0]  myTimeslot, round_cnt;

    node_info_engine dut (
        .clk(clk), .nrst(nrst), .en_MNI(en_MNI), .fPktType(fPktType),
        .energy(energy), .destinationID(destinationID), .hops(hops),
        .timeslot(timeslot), .e_threshold(e_threshold),
        .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
        .role(role), .low_E(low_E), .hb_lock(hb_lock), .myTimeslot(myTimeslot),
        .ts_valid(ts_valid), .round_cnt(round_cnt), .busy(busy), .done(done),
        .pkt_dropped(pkt_dropped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference node state
    int m_hops, m_q, m_ts, m_rc;
    bit m_role, m_lowe, m_lock, m_tsv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hops = 16'hFFFF; m_q = 0; m_ts = 0; m_rc = 0;
        m_role = 0; m_lowe = 0; m_lock = 0; m_tsv = 0;
    endtask

    task automatic model_apply(input int t, input int e, input int d, input int h_in,
                               input int ts, input int thr, output bit drop);
        int h;
        longint cost;
        drop = 0;
        case (t)
            0: begin
                if (m_lock) drop = 1;
                else begin
                    h      = (h_in == 16'hFFFF) ? 16'hFFFF : h_in + 1;
                    cost   = longint'(h) * 1024;
                    m_q    = (cost >= e) ? 0 : e - int'(cost);
                    m_hops = h;
                    m_lowe = (e < thr);
                    m_lock = 1;
                    m_role = 0;
                    m_tsv  = 0;
                    m_rc   = (m_rc + 1) % 256;
                end
            end
            1: if (d == NID && m_lock) m_role = 1;
            4: if (!m_role && d == NID) begin m_ts = ts % 256; m_tsv = 1; end
            5: m_lock = 0;
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".id"},    myNodeID,     NID);
        chk({tag, ".hops"},  hopsFromSink, m_hops);
        chk({tag, ".q"},     myQValue,     m_q);
        chk({tag, ".role"},  role,         m_role);
        chk({tag, ".lowE"},  low_E,        m_lowe);
        chk({tag, ".lock"},  hb_lock,      m_lock);
        chk({tag, ".ts"},    myTimeslot,   m_ts);
        chk({tag, ".tsv"},   ts_valid,     m_tsv);
        chk({tag, ".rc"},    round_cnt,    m_rc);
    endtask

    // One packet: strobe, optional ignored strobe during EXEC, exact-latency done check, state check.
    task automatic send(input string tag, input logic [2:0] t, input logic [15:0] e, input logic [15:0] d,
                        input logic [15:0] h, input logic [15:0] ts, input logic [15:0] thr,
                        input bit glitch);
        bit drop;
        @(negedge clk);
        fPktType = t; energy = e; destinationID = d; hops = h; timeslot = ts; e_threshold = thr;
        en_MNI = 1'b1;
        @(negedge clk);
        en_MNI = glitch;
        if (glitch) begin
            fPktType = 3'b000; destinationID = NID; hops = 16'h0000; energy = 16'hFFFF;
        end
        model_apply(int'(t), int'(e), int'(d), int'(h), int'(ts), int'(thr), drop);
        @(posedge clk); #1;
        chk({tag, ".done_early"}, done, 1'b0);
        chk({tag, ".busy"},       busy, 1'b1);
        @(negedge clk);
        en_MNI = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".drop"}, pkt_dropped, drop);
        check_state(tag);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".drop_pulse"}, pkt_dropped, 1'b0);
        chk({tag, ".idle"},       busy, 1'b0);
    endtask

    initial begin
        nrst = 1'b1; en_MNI = 1'b0; fPktType = '0; energy = '0; destinationID = '0;
        hops = '0; timeslot = '0; e_threshold = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("rst");
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        @(negedge clk);
        nrst = 1'b0;

        // directed walk-through
        send("t1_hb",     3'b000, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h3333, 0);
        chk("t1.q_abs", myQValue, 16'h7800);
        send("t2_hb_dup", 3'b000, 16'h7FC0, 16'h0000, 16'h0002, 16'h0000, 16'h3333, 0);
        send("t3_che_x",  3'b001, 16'h0000, 16'd32,   16'h0000, 16'h0000, 16'h3333, 0);
        send("t3_inv",    3'b010, 16'h0000, 16'd32,   16'h0000, 16'h0000, 16'h3333, 0);
        send("t3_che",    3'b001, 16'h0000, NID,      16'h0000, 16'h0000, 16'h3333, 1);
        chk("t3.role_abs", role, 1'b1);
        send("t3_chts",   3'b100, 16'h0000, NID,      16'h0000, 16'h0005, 16'h3333, 0);
        send("t4_data",   3'b101, 16'h0000, 16'd14,   16'h0000, 16'h0000, 16'h3333, 0);
        send("t4_hb",     3'b000, 16'h3000, 16'h0000, 16'h0003, 16'h0000, 16'h3333, 0);
        chk("t4.q_abs", myQValue, 16'h2000);
        send("t4_chts",   3'b100, 16'h0000, NID,      16'h0000, 16'h0105, 16'h3333, 0);
        chk("t4.ts_abs", myTimeslot, 8'h05);
        send("t5_data",   3'b101, 16'h0000, 16'd14,   16'h0000, 16'h0000, 16'h3333, 0);
        send("t5_hb_sat", 3'b000, 16'h0100, 16'h0000, 16'hFFFF, 16'h0000, 16'h3333, 0);
        for (int i = 3; i < 8; i++) begin
            if (i != 4 && i != 5)
                send("rsvd", 3'(i), 16'hFFFF, NID, 16'h0001, 16'h0009, 16'h0000, 0);
        end

        // reset while EXEC: nothing commits, outputs return to reset values
        @(negedge clk);
        fPktType = 3'b101; destinationID = NID; en_MNI = 1'b1;
        @(negedge clk);
        en_MNI = 1'b0;
        nrst = 1'b1;
        model_reset();
        #1;
        check_state("t6_rst");
        chk("t6_rst.busy", busy, 1'b0);
        @(negedge clk);
        nrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t6_no_done", done, 1'b0);
        end

        // round counter wrap
        for (int i = 0; i < 258; i++) begin
            send("wrap_hb",   3'b000, 16'(($urandom & 16'hFFFF)), 16'h0000, 16'($urandom_range(0, 60)),
                 16'h0000, 16'h4000, 0);
            send("wrap_data", 3'b101, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0);
        end

        // randomized packet mix
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [2:0] t;
            logic [15:0] d, h;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: t = 3'b000;
                3, 9:    t = 3'b001;
                4:       t = 3'b100;
                5, 6:    t = 3'b101;
                7:       t = 3'b010;
                default: t = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'(6 + $urandom_range(0, 1));
            endcase
            d = ($urandom_range(0, 1) == 0) ? NID : 16'($urandom);
            case ($urandom_range(0, 7))
                0:       h = 16'hFFFF;
                1:       h = 16'($urandom);
                default: h = 16'($urandom_range(0, 40));
            endcase
            send("rand", t, 16'($urandom), d, h, 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
